// File: rtl/capture_timer_array_if.sv
// Control/status bundle of the multi-channel capture/compare timer.
// The block owns the slave side; whoever drives the controls owns the master side.
interface capture_timer_array_if #(
   parameter int TIMER_BITWIDTH    = 32,
   parameter int NB_CHANNELS       = 10,
   parameter int PRESCALE_BITWIDTH = 8
);
   logic [PRESCALE_BITWIDTH-1:0]          prescale_in;
   logic [NB_CHANNELS-1:0]                start_in;
   logic [NB_CHANNELS-1:0]                stop_in;
   logic [NB_CHANNELS-1:0]                capture_in;
   logic [NB_CHANNELS-1:0]                rst_capture_in;
   logic [NB_CHANNELS-1:0]                mode_periodic_in;
   logic [NB_CHANNELS-1:0]                alarm_en_in;
   logic [NB_CHANNELS-1:0]                alarm_clr_in;
   logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] alarm_in;
   logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] counter_out;
   logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] captured_out;
   logic [NB_CHANNELS-1:0]                alarm_out;
   logic [NB_CHANNELS-1:0]                alarm_pulse_out;
   logic [NB_CHANNELS-1:0]                overflow_out;
   logic [NB_CHANNELS-1:0]                running_out;

   modport master (
      output prescale_in, start_in, stop_in, capture_in, rst_capture_in,
             mode_periodic_in, alarm_en_in, alarm_clr_in, alarm_in,
      input  counter_out, captured_out, alarm_out, alarm_pulse_out,
             overflow_out, running_out
   );

   modport slave (
      input  prescale_in, start_in, stop_in, capture_in, rst_capture_in,
             mode_periodic_in, alarm_en_in, alarm_clr_in, alarm_in,
      output counter_out, captured_out, alarm_out, alarm_pulse_out,
             overflow_out, running_out
   );
endinterface

// File: rtl/capture_timer_array.sv
// Multi-channel capture/compare timer: shared tick prescaler, per-channel
// IDLE/RUN/DONE FSM with one-shot or auto-reload alarm, capture and overflow flags.
module capture_timer_array #(
   parameter int TIMER_BITWIDTH    = 32,
   parameter int NB_CHANNELS       = 10,
   parameter int PRESCALE_BITWIDTH = 8
) (
   input logic                   clk_in,
   input logic                   rst_an_in,
   input logic                   rst_in,
   capture_timer_array_if.slave  bus
);
   localparam int TW = TIMER_BITWIDTH;
   localparam int NC = NB_CHANNELS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic                         rst_meta;
   logic                         rst_sync_n;
   logic [PRESCALE_BITWIDTH-1:0] pre_cnt_q;
   logic                         tick;

   logic [NC-1:0] start_prev_q, stop_prev_q, cap_prev_q, rst_cap_prev_q;
   logic [NC-1:0] start_rise, stop_rise, cap_rise, rst_cap_rise;

   state_t        state_q [NC];
   state_t        state_d [NC];
   logic [TW-1:0] cnt_q   [NC];
   logic [TW-1:0] cnt_d   [NC];
   logic [TW-1:0] cap_q   [NC];
   logic [TW-1:0] cap_d   [NC];
   logic [TW-1:0] alarm_w [NC];
   logic [NC-1:0] alarm_q, alarm_d;
   logic [NC-1:0] pulse_q, pulse_d;
   logic [NC-1:0] ovf_q, ovf_d;
   logic [NC-1:0] running_q, running_d;

   // Assertion is immediate; release is retimed through two flops.
   always_ff @(posedge clk_in or negedge rst_an_in) begin
      if (!rst_an_in) begin
         rst_meta   <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_n <= rst_meta;
      end
   end

   assign tick = (pre_cnt_q >= bus.prescale_in);

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         pre_cnt_q <= '0;
      end else if (rst_in) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= tick ? '0 : pre_cnt_q + PRESCALE_BITWIDTH'(1);
      end
   end

   // Prev registers reset to 1 so a level held through reset is not an event.
   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         start_prev_q   <= '1;
         stop_prev_q    <= '1;
         cap_prev_q     <= '1;
         rst_cap_prev_q <= '1;
      end else if (rst_in) begin
         start_prev_q   <= '1;
         stop_prev_q    <= '1;
         cap_prev_q     <= '1;
         rst_cap_prev_q <= '1;
      end else begin
         start_prev_q   <= bus.start_in;
         stop_prev_q    <= bus.stop_in;
         cap_prev_q     <= bus.capture_in;
         rst_cap_prev_q <= bus.rst_capture_in;
      end
   end

   assign start_rise   = bus.start_in       & ~start_prev_q;
   assign stop_rise    = bus.stop_in        & ~stop_prev_q;
   assign cap_rise     = bus.capture_in     & ~cap_prev_q;
   assign rst_cap_rise = bus.rst_capture_in & ~rst_cap_prev_q;

   for (genvar g = 0; g < NC; g++) begin : g_ch_io
      assign alarm_w[g]                     = bus.alarm_in[g*TW +: TW];
      assign bus.counter_out[g*TW +: TW]    = cnt_q[g];
      assign bus.captured_out[g*TW +: TW]   = cap_q[g];
   end

   assign bus.alarm_out       = alarm_q;
   assign bus.alarm_pulse_out = pulse_q;
   assign bus.overflow_out    = ovf_q;
   assign bus.running_out     = running_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      alarm_d   = alarm_q & ~bus.alarm_clr_in;
      pulse_d   = '0;
      ovf_d     = ovf_q;
      running_d = '0;
      for (int i = 0; i < NC; i++) begin
         if (rst_cap_rise[i]) begin
            cnt_d[i]   = '0;
            cap_d[i]   = '0;
            ovf_d[i]   = 1'b0;
            alarm_d[i] = 1'b0;
            state_d[i] = IDLE;
         end else begin
            if (cap_rise[i]) cap_d[i] = cnt_q[i];
            if (stop_rise[i]) begin
               if (state_q[i] == RUN) state_d[i] = IDLE;
            end else if (start_rise[i]) begin
               if (state_q[i] == IDLE) begin
                  state_d[i] = RUN;
               end else if (state_q[i] == DONE) begin
                  cnt_d[i]   = '0;
                  state_d[i] = RUN;
               end
            end else if (tick && state_q[i] == RUN) begin
               if (bus.alarm_en_in[i] && cnt_q[i] == alarm_w[i]) begin
                  pulse_d[i] = 1'b1;
                  alarm_d[i] = 1'b1;
                  if (bus.mode_periodic_in[i]) cnt_d[i]   = '0;
                  else                         state_d[i] = DONE;
               end else begin
                  cnt_d[i] = cnt_q[i] + TIMER_BITWIDTH'(1);
                  if (&cnt_q[i]) ovf_d[i] = 1'b1;
               end
            end
         end
         running_d[i] = (state_d[i] == RUN);
      end
   end

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         for (int i = 0; i < NC; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            cap_q[i]   <= '0;
         end
         alarm_q   <= '0;
         pulse_q   <= '0;
         ovf_q     <= '0;
         running_q <= '0;
      end else if (rst_in) begin
         for (int i = 0; i < NC; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            cap_q[i]   <= '0;
         end
         alarm_q   <= '0;
         pulse_q   <= '0;
         ovf_q     <= '0;
         running_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         alarm_q   <= alarm_d;
         pulse_q   <= pulse_d;
         ovf_q     <= ovf_d;
         running_q <= running_d;
      end
   end
endmodule

// File: doc/capture_timer_array.md
# capture_timer_array

Multi-channel capture/compare timer: the parametrised successor of the single-mode timer top. It adds a shared tick prescaler, per-channel start/stop control, and one-shot or periodic (auto-reload) alarm modes. It also adds an overflow flag and a single-cycle alarm pulse next to the sticky alarm. It sits in the same clock domain as the existing timer and drives the same capture, counter and alarm consumers.

## Interface
- TIMER_BITWIDTH, 32, width of each channel counter, capture and alarm word
- NB_CHANNELS, 10, number of independent channels
- PRESCALE_BITWIDTH, 8, width of the prescale setting
- clk_in  in  1  single clock, all logic on rising edge
- rst_an_in  in  1  asynchronous, active-low reset; deassertion internally synchronised with a 2-flop synchroniser
- rst_in  in  1  synchronous active-high clear of all state
- prescale_in  in  PRESCALE_BITWIDTH  tick every prescale_in+1 cycles
- start_in / stop_in / capture_in / rst_capture_in  in  NB_CHANNELS each  level inputs, acted on at rising edge
- mode_periodic_in  in  NB_CHANNELS  1 = auto-reload on alarm match, 0 = one-shot
- alarm_en_in  in  NB_CHANNELS  enables compare
- alarm_in  in  TIMER_BITWIDTH*NB_CHANNELS  compare values, channel i at [i*TW +: TW]
- alarm_clr_in  in  NB_CHANNELS  level, clears sticky alarm
- counter_out / captured_out  out  TIMER_BITWIDTH*NB_CHANNELS  live counter / last captured value
- alarm_out  out  NB_CHANNELS  sticky alarm flag
- alarm_pulse_out  out  NB_CHANNELS  one-cycle match pulse
- overflow_out  out  NB_CHANNELS  sticky counter wrap flag
- running_out  out  NB_CHANNELS  channel in RUN

## Operation
- Edge detect: per input bit, prev register reset to 1; rise = in & ~prev. An input held high through reset produces no event.
- Prescaler: shared pre_cnt. tick when pre_cnt >= prescale_in, then pre_cnt <= 0; otherwise pre_cnt+1. prescale_in=0 gives a tick every cycle. Lowering prescale_in below pre_cnt fires on the next cycle.
- Per-channel FSM states IDLE, RUN, DONE.
  - IDLE: counter held. start rise -> RUN.
  - RUN: stop rise -> IDLE, counter retained. On tick with alarm_en=1 and counter==alarm_in: match. On match, periodic -> counter <= 0, stay RUN; one-shot -> DONE, counter holds the alarm value. On tick without match: counter+1.
  - DONE: start rise -> counter <= 0, RUN.
- Overflow: in RUN, a tick without match at counter=all-ones wraps to 0 and sets overflow_out. The flag is sticky.
- Capture rise (any state): captured <= counter value before this edge's update.
- rst_capture rise: counter, captured, overflow and alarm all go to 0; state -> IDLE.
- Alarm: match sets alarm_out and pulses alarm_pulse_out for exactly one cycle. alarm_clr_in clears alarm_out; a match in the same cycle wins (flag stays 1).
- alarm_in and mode_periodic_in are compared/used live, with no shadowing.
- Priority per channel: rst_in > rst_capture rise > stop rise > start rise > tick. Capture is orthogonal except under rst_capture, where captured is cleared.
- Channels are fully independent apart from the shared prescaler.
- Reset values (rst_an_in low or rst_in high): all counters, captures and flags are 0; all channels IDLE; pre_cnt 0; all prev registers 1.

## Timing
- Control latency: an input sampled high at edge k (with prev 0) has its effect registered at edge k, visible after edge k.
- running_out is registered from the state.
- counter_out, captured_out and flags are direct register outputs, with no combinational path from inputs.
- alarm_pulse_out is high in the cycle following the matching edge, coincident with alarm_out first reading 1.
- Periodic mode with alarm=N and prescale 0: counter sequence 0..N,0..N; period N+1 ticks.
- rst_an_in asserts asynchronously mid-operation: all outputs go to reset values immediately. Release takes effect 2 clk_in edges later.

## Test plan
- Prescale 0, channel 0 one-shot, alarm=3, start rise: counter 0,1,2,3 then held in DONE; alarm_pulse_out 1 for one cycle; alarm_out sticky; running_out 0.
- Periodic, alarm=4, prescale=2: counter increments every 3 cycles and reloads 4->0. alarm_pulse_out fires every 15 cycles. alarm_clr_in coincident with a match leaves alarm_out=1.
- TIMER_BITWIDTH=8, alarm_en=0: counter 255->0; overflow_out=1 until rst_capture rise, which zeroes counter, captured and flags.
- Capture rise on the same cycle as a tick at counter=7: captured_out=7, counter_out=8. Stop rise then holds the counter; a new start rise resumes from the held value.
- Simultaneous start and stop rise in IDLE: stays IDLE. Start held high during reset release: no start event.
- rst_an_in pulsed low while 3 channels run: all outputs 0 asynchronously; channels stay IDLE after release until a new start rise.
